// File: rtl/branch_resolve_ctrl.sv
// Branch resolution sequencer: latches one EX-stage branch, drives the shared comparator,
// resolves direction against the prediction and issues redirect plus a timed flush.
module branch_resolve_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter logic [31:0] PC_INC       = 32'd4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  br_op,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic [31:0] pc,
  input  logic [31:0] imm,
  input  logic        pred_taken,
  input  logic        kill,
  output logic [31:0] cmp_c,
  input  logic [1:0]  cmp_code,
  output logic        resp_valid,
  output logic        resp_taken,
  output logic        mispredict,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        flush,
  output logic        busy
);

  // Comparator result encoding shared with the comparator block.
  localparam logic [1:0] CODE_EQ = 2'b00;
  localparam logic [1:0] CODE_LT = 2'b01;
  localparam logic [1:0] CODE_GT = 2'b10;

  localparam logic [2:0] OP_BEQ = 3'd0;
  localparam logic [2:0] OP_BNE = 3'd1;
  localparam logic [2:0] OP_BLT = 3'd2;
  localparam logic [2:0] OP_BGE = 3'd3;
  localparam logic [2:0] OP_BLE = 3'd4;
  localparam logic [2:0] OP_BGT = 3'd5;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CMP   = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

  logic [1:0]  r_state;
  logic [2:0]  r_op;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [31:0] r_pc;
  logic [31:0] r_imm;
  logic        r_pred;
  logic [3:0]  r_flush_cnt;
  logic        r_resp_valid;
  logic        r_resp_taken;
  logic        r_mispredict;
  logic        r_redirect_valid;
  logic [31:0] r_redirect_pc;

  logic [32:0] w_diff;
  logic        w_ovf;
  logic        w_taken;
  logic        w_misp;

  // On signed overflow, keep the true sign and force a nonzero magnitude.
  assign w_diff = {r_a[31], r_a} - {r_b[31], r_b};
  assign w_ovf  = w_diff[32] ^ w_diff[31];
  assign cmp_c  = w_ovf ? {w_diff[32], 31'h1} : w_diff[31:0];

  always_comb begin
    w_taken = 1'b0;
    case (r_op)
      OP_BEQ:  w_taken = (cmp_code == CODE_EQ);
      OP_BNE:  w_taken = (cmp_code != CODE_EQ);
      OP_BLT:  w_taken = (cmp_code == CODE_LT);
      OP_BGE:  w_taken = (cmp_code != CODE_LT);
      OP_BLE:  w_taken = (cmp_code != CODE_GT);
      OP_BGT:  w_taken = (cmp_code == CODE_GT);
      default: w_taken = 1'b0;
    endcase
  end

  assign w_misp = w_taken ^ r_pred;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state          <= S_IDLE;
      r_op             <= 3'd0;
      r_a              <= 32'd0;
      r_b              <= 32'd0;
      r_pc             <= 32'd0;
      r_imm            <= 32'd0;
      r_pred           <= 1'b0;
      r_flush_cnt      <= 4'd0;
      r_resp_valid     <= 1'b0;
      r_resp_taken     <= 1'b0;
      r_mispredict     <= 1'b0;
      r_redirect_valid <= 1'b0;
      r_redirect_pc    <= 32'd0;
    end else begin
      r_resp_valid     <= 1'b0;
      r_redirect_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req_valid && !kill) begin
            r_op    <= br_op;
            r_a     <= op_a;
            r_b     <= op_b;
            r_pc    <= pc;
            r_imm   <= imm;
            r_pred  <= pred_taken;
            r_state <= S_CMP;
          end
        end
        S_CMP: begin
          if (kill) begin
            r_state <= S_IDLE;
          end else begin
            r_resp_valid     <= 1'b1;
            r_resp_taken     <= w_taken;
            r_mispredict     <= w_misp;
            r_redirect_valid <= w_misp;
            r_redirect_pc    <= w_taken ? (r_pc + r_imm) : (r_pc + PC_INC);
            r_flush_cnt      <= FLUSH_LOAD;
            r_state          <= w_misp ? S_FLUSH : S_IDLE;
          end
        end
        S_FLUSH: begin
          if (r_flush_cnt == 4'd0) begin
            r_state <= S_IDLE;
          end else begin
            r_flush_cnt <= r_flush_cnt - 4'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready      = (r_state == S_IDLE);
  assign busy           = (r_state != S_IDLE);
  assign flush          = (r_state == S_FLUSH);
  assign resp_valid     = r_resp_valid;
  assign resp_taken     = r_resp_taken;
  assign mispredict     = r_mispredict;
  assign redirect_valid = r_redirect_valid;
  assign redirect_pc    = r_redirect_pc;

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Bench for branch_resolve_ctrl: two instances (flush length 2 and 3) share stimulus and are
// checked every cycle against a transaction-level model, plus literal pins of the directed cases.
module tb_branch_resolve_ctrl;

  localparam logic [1:0] C_EQ = 2'b00;
  localparam logic [1:0] C_LT = 2'b01;
  localparam logic [1:0] C_GT = 2'b10;
  localparam int NDUT = 2;

  int fc_of [NDUT] = '{2, 3};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic [2:0]  br_op = 3'd0;
  logic [31:0] op_a = 32'd0;
  logic [31:0] op_b = 32'd0;
  logic [31:0] pc = 32'd0;
  logic [31:0] imm = 32'd0;
  logic        pred_taken = 1'b0;
  logic        kill = 1'b0;

  logic        o_ready [NDUT];
  logic        o_busy  [NDUT];
  logic        o_flush [NDUT];
  logic        o_rv    [NDUT];
  logic        o_rt    [NDUT];
  logic        o_mp    [NDUT];
  logic        o_redv  [NDUT];
  logic [31:0] o_rpc   [NDUT];
  logic [31:0] o_cmp_c [NDUT];
  logic [1:0]  cmp_code [NDUT];

  always #5 clk = ~clk;

  // Shared comparator: signed sign/zero test of the difference operand.
  function automatic logic [1:0] comparator(input logic [31:0] c);
    if (c == 32'd0) return C_EQ;
    if ($signed(c) < 0) return C_LT;
    return C_GT;
  endfunction

  assign cmp_code[0] = comparator(o_cmp_c[0]);
  assign cmp_code[1] = comparator(o_cmp_c[1]);

  branch_resolve_ctrl #(.FLUSH_CYCLES(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(o_ready[0]),
    .br_op(br_op), .op_a(op_a), .op_b(op_b), .pc(pc), .imm(imm),
    .pred_taken(pred_taken), .kill(kill), .cmp_c(o_cmp_c[0]), .cmp_code(cmp_code[0]),
    .resp_valid(o_rv[0]), .resp_taken(o_rt[0]), .mispredict(o_mp[0]),
    .redirect_valid(o_redv[0]), .redirect_pc(o_rpc[0]), .flush(o_flush[0]), .busy(o_busy[0])
  );

  branch_resolve_ctrl #(.FLUSH_CYCLES(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(o_ready[1]),
    .br_op(br_op), .op_a(op_a), .op_b(op_b), .pc(pc), .imm(imm),
    .pred_taken(pred_taken), .kill(kill), .cmp_c(o_cmp_c[1]), .cmp_code(cmp_code[1]),
    .resp_valid(o_rv[1]), .resp_taken(o_rt[1]), .mispredict(o_mp[1]),
    .redirect_valid(o_redv[1]), .redirect_pc(o_rpc[1]), .flush(o_flush[1]), .busy(o_busy[1])
  );

  // Model state: a branch in its compare cycle, remaining flush cycles, last resolution.
  bit          m_cmp        [NDUT];
  int          m_flush_left [NDUT];
  logic [2:0]  m_op   [NDUT];
  logic [31:0] m_a    [NDUT];
  logic [31:0] m_b    [NDUT];
  logic [31:0] m_pc   [NDUT];
  logic [31:0] m_imm  [NDUT];
  bit          m_pred [NDUT];
  bit          e_rv   [NDUT];
  bit          e_rt   [NDUT];
  bit          e_mp   [NDUT];
  bit          e_redv [NDUT];
  logic [31:0] e_rpc  [NDUT];

  int total = 0;
  int bad = 0;
  int cyc = 0;

  function automatic logic [31:0] exp_cmp_c(input logic [31:0] a, input logic [31:0] b);
    longint d;
    d = longint'($signed(a)) - longint'($signed(b));
    if (d > 64'sd2147483647) return 32'h0000_0001;
    if (d < -64'sd2147483648) return 32'h8000_0001;
    return d[31:0];
  endfunction

  function automatic bit exp_taken(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int sa;
    int sb;
    sa = a;
    sb = b;
    case (op)
      3'd0:    return sa == sb;
      3'd1:    return sa != sb;
      3'd2:    return sa < sb;
      3'd3:    return sa >= sb;
      3'd4:    return sa <= sb;
      3'd5:    return sa > sb;
      default: return 1'b0;
    endcase
  endfunction

  task automatic check_b(input string name, input int d, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d cyc=%0d got=%b want=%b", name, d, cyc, act, exp);
    end
  endtask

  task automatic check_w(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d cyc=%0d got=%h want=%h", name, d, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < NDUT; d++) begin
      m_cmp[d] = 1'b0;
      m_flush_left[d] = 0;
      m_op[d] = 3'd0;
      m_a[d] = 32'd0;
      m_b[d] = 32'd0;
      m_pc[d] = 32'd0;
      m_imm[d] = 32'd0;
      m_pred[d] = 1'b0;
      e_rv[d] = 1'b0;
      e_rt[d] = 1'b0;
      e_mp[d] = 1'b0;
      e_redv[d] = 1'b0;
      e_rpc[d] = 32'd0;
    end
  endtask

  task automatic model_edge(input int d);
    bit t;
    e_rv[d] = 1'b0;
    e_redv[d] = 1'b0;
    if (m_cmp[d]) begin
      m_cmp[d] = 1'b0;
      if (!kill) begin
        t = exp_taken(m_op[d], m_a[d], m_b[d]);
        e_rv[d] = 1'b1;
        e_rt[d] = t;
        e_mp[d] = (t != m_pred[d]);
        e_redv[d] = e_mp[d];
        e_rpc[d] = t ? (m_pc[d] + m_imm[d]) : (m_pc[d] + 32'd4);
        if (e_mp[d]) m_flush_left[d] = fc_of[d];
      end
    end else if (m_flush_left[d] > 0) begin
      m_flush_left[d]--;
    end else if (req_valid && !kill) begin
      m_cmp[d] = 1'b1;
      m_op[d] = br_op;
      m_a[d] = op_a;
      m_b[d] = op_b;
      m_pc[d] = pc;
      m_imm[d] = imm;
      m_pred[d] = pred_taken;
    end
  endtask

  task automatic compare(input int d);
    bit idle;
    idle = !m_cmp[d] && (m_flush_left[d] == 0);
    check_b("req_ready", d, o_ready[d], idle);
    check_b("busy", d, o_busy[d], !idle);
    check_b("flush", d, o_flush[d], m_flush_left[d] > 0);
    check_b("resp_valid", d, o_rv[d], e_rv[d]);
    check_b("redirect_valid", d, o_redv[d], e_redv[d]);
    if (e_rv[d]) begin
      check_b("resp_taken", d, o_rt[d], e_rt[d]);
      check_b("mispredict", d, o_mp[d], e_mp[d]);
      check_w("redirect_pc", d, o_rpc[d], e_rpc[d]);
      if (d == 0)
        $display("resp cyc=%0d taken=%0b misp=%0b redirect_pc=%h", cyc, e_rt[d], e_mp[d], e_rpc[d]);
    end
    if (m_cmp[d]) check_w("cmp_c", d, o_cmp_c[d], exp_cmp_c(m_a[d], m_b[d]));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    for (int d = 0; d < NDUT; d++) begin
      model_edge(d);
      compare(d);
    end
  endtask

  task automatic set_req(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] p, input logic [31:0] i, input logic pr);
    req_valid = 1'b1;
    br_op = op;
    op_a = a;
    op_b = b;
    pc = p;
    imm = i;
    pred_taken = pr;
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    kill = 1'b0;
    repeat (n) step();
  endtask

  task automatic check_reset_values(input string tag);
    for (int d = 0; d < NDUT; d++) begin
      check_b({tag, "_ready"}, d, o_ready[d], 1'b1);
      check_b({tag, "_busy"}, d, o_busy[d], 1'b0);
      check_b({tag, "_flush"}, d, o_flush[d], 1'b0);
      check_b({tag, "_rv"}, d, o_rv[d], 1'b0);
      check_b({tag, "_rt"}, d, o_rt[d], 1'b0);
      check_b({tag, "_mp"}, d, o_mp[d], 1'b0);
      check_b({tag, "_redv"}, d, o_redv[d], 1'b0);
      check_w({tag, "_rpc"}, d, o_rpc[d], 32'd0);
      check_w({tag, "_cmp_c"}, d, o_cmp_c[d], 32'd0);
    end
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'($urandom_range(0, 7));
      1:       return 32'h8000_0000;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    model_reset();
    #2;
    check_reset_values("reset");
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // BEQ 5,5 predicted not-taken: mispredict, redirect to pc+imm, two-cycle flush.
    set_req(3'd0, 32'd5, 32'd5, 32'h100, 32'h20, 1'b0);
    step();
    check_w("t1_cmp_c", 0, o_cmp_c[0], 32'd0);
    check_b("t1_ready_cmp", 0, o_ready[0], 1'b0);
    req_valid = 1'b0;
    step();
    check_b("t1_rv", 0, o_rv[0], 1'b1);
    check_b("t1_rt", 0, o_rt[0], 1'b1);
    check_b("t1_mp", 0, o_mp[0], 1'b1);
    check_b("t1_redv", 0, o_redv[0], 1'b1);
    check_w("t1_rpc", 0, o_rpc[0], 32'h120);
    check_b("t1_flush1", 0, o_flush[0], 1'b1);
    step();
    check_b("t1_flush2", 0, o_flush[0], 1'b1);
    check_b("t1_ready_f2", 0, o_ready[0], 1'b0);
    step();
    check_b("t1_flush_end", 0, o_flush[0], 1'b0);
    check_b("t1_ready_back", 0, o_ready[0], 1'b1);
    check_b("t1_dut3_flush3", 1, o_flush[1], 1'b1);
    idle(3);

    // BLT on the overflow path, correctly predicted.
    set_req(3'd2, 32'h8000_0000, 32'd1, 32'h200, 32'h10, 1'b1);
    step();
    check_w("t2_cmp_c", 0, o_cmp_c[0], 32'h8000_0001);
    check_b("t2_code_lt", 0, cmp_code[0] == C_LT, 1'b1);
    req_valid = 1'b0;
    step();
    check_b("t2_rv", 0, o_rv[0], 1'b1);
    check_b("t2_rt", 0, o_rt[0], 1'b1);
    check_b("t2_mp", 0, o_mp[0], 1'b0);
    check_b("t2_redv", 0, o_redv[0], 1'b0);
    check_b("t2_ready", 0, o_ready[0], 1'b1);
    idle(2);

    // BGE 3,7 mispredicted taken: fall-through wraps to zero.
    set_req(3'd3, 32'd3, 32'd7, 32'hFFFF_FFFC, 32'h40, 1'b1);
    step();
    req_valid = 1'b0;
    step();
    check_b("t3_rt", 0, o_rt[0], 1'b0);
    check_b("t3_mp", 0, o_mp[0], 1'b1);
    check_w("t3_rpc", 0, o_rpc[0], 32'h0);
    idle(5);

    // Back-to-back BNE then BGT, second accepted on the first resp cycle.
    set_req(3'd1, 32'd1, 32'd2, 32'h300, 32'h8, 1'b1);
    step();
    req_valid = 1'b0;
    step();
    check_b("t4_rv1", 0, o_rv[0], 1'b1);
    check_b("t4_ready1", 0, o_ready[0], 1'b1);
    set_req(3'd5, 32'd9, 32'd4, 32'h304, 32'hC, 1'b1);
    step();
    check_b("t4_gap", 0, o_rv[0], 1'b0);
    req_valid = 1'b0;
    step();
    check_b("t4_rv2", 0, o_rv[0], 1'b1);
    check_b("t4_rt2", 0, o_rt[0], 1'b1);
    check_b("t4_mp2", 0, o_mp[0], 1'b0);
    check_b("t4_flush", 0, o_flush[0], 1'b0);
    idle(2);

    // kill during CMP of a mispredicting BEQ.
    set_req(3'd0, 32'd5, 32'd5, 32'h400, 32'h20, 1'b0);
    step();
    req_valid = 1'b0;
    kill = 1'b1;
    step();
    kill = 1'b0;
    check_b("t5_rv", 0, o_rv[0], 1'b0);
    check_b("t5_redv", 0, o_redv[0], 1'b0);
    check_b("t5_flush", 0, o_flush[0], 1'b0);
    check_b("t5_ready", 0, o_ready[0], 1'b1);
    step();
    check_b("t5_rv_late", 0, o_rv[0], 1'b0);
    check_b("t5_flush_late", 0, o_flush[0], 1'b0);
    idle(2);

    // Reset asserted in the middle of a flush.
    set_req(3'd0, 32'd5, 32'd5, 32'h500, 32'h20, 1'b0);
    step();
    req_valid = 1'b0;
    step();
    step();
    check_b("t6_dut3_in_flush", 1, o_flush[1], 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_reset_values("t6_async");
    @(negedge clk);
    rst_n = 1'b1;
    set_req(3'd7, 32'd1, 32'd1, 32'h600, 32'h80, 1'b1);
    step();
    req_valid = 1'b0;
    step();
    check_b("t6_rv", 0, o_rv[0], 1'b1);
    check_b("t6_rt", 0, o_rt[0], 1'b0);
    check_b("t6_mp", 0, o_mp[0], 1'b1);
    check_w("t6_rpc", 0, o_rpc[0], 32'h604);
    idle(5);

    for (int n = 0; n < 3000; n++) begin
      req_valid = ($urandom_range(0, 9) < 6);
      kill = ($urandom_range(0, 9) == 0);
      br_op = 3'($urandom_range(0, 7));
      op_a = pick_operand();
      op_b = pick_operand();
      pc = $urandom;
      imm = $urandom;
      pred_taken = 1'($urandom_range(0, 1));
      step();
    end
    idle(6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/branch_resolve_ctrl.md
Name: branch_resolve_ctrl

Overview:
- Sequences branch resolution for the pipelined CPU.
- Accepts one branch request at a time from the EX stage and drives the shared branch comparator with the difference operand.
- Samples the comparator's 2-bit `EQ/`LT/`GT result and evaluates the branch condition against the front-end prediction.
- On mispredict, issues a PC redirect followed by a timed pipeline flush.

Parameters:
- FLUSH_CYCLES, 2, number of cycles flush is held after a mispredict (legal range 1..15).
- PC_INC, 4, fall-through increment added to pc when not taken.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  1  branch request valid
- req_ready  output  1  controller can accept a request
- br_op  input  3  0=BEQ 1=BNE 2=BLT 3=BGE 4=BLE 5=BGT, 6/7 reserved
- op_a  input  32  rs1 value, signed
- op_b  input  32  rs2 value, signed
- pc  input  32  branch instruction PC
- imm  input  32  sign-extended branch offset
- pred_taken  input  1  front-end prediction for this branch
- kill  input  1  synchronous abort of the in-flight branch (older exception)
- cmp_c  output  32  difference operand to the shared comparator
- cmp_code  input  2  comparator result (`EQ/`LT/`GT, combinational from cmp_c)
- resp_valid  output  1  one-cycle resolution pulse
- resp_taken  output  1  resolved direction
- mispredict  output  1  resp_taken != latched pred_taken (valid with resp_valid)
- redirect_valid  output  1  one-cycle PC redirect pulse
- redirect_pc  output  32  correct next PC
- flush  output  1  flush younger pipeline stages
- busy  output  1  state != IDLE

Behaviour:
- Reset values (async, rst_n low):
  - state=IDLE, req_ready=1, busy=0, flush=0.
  - resp_valid=0, resp_taken=0, mispredict=0, redirect_valid=0.
  - redirect_pc=0, cmp_c=0, all latched operands 0.
- IDLE:
  - req_ready=1.
  - Accept on req_valid & req_ready: latch br_op, op_a, op_b, pc, imm, pred_taken; next state CMP.
- CMP (exactly one cycle):
  - req_ready=0.
  - cmp_c is driven from the latched operands.
  - cmp_code is sampled at the end of the cycle.
- cmp_c arithmetic:
  - Compute the 33-bit signed difference d = sext(a) - sext(b).
  - If d[32]==d[31] (no overflow): cmp_c = d[31:0].
  - On overflow: cmp_c = {d[32], 31'h1}. This guarantees a correct sign and a nonzero value.
- Condition evaluation (end of CMP):
  - BEQ: code==`EQ
  - BNE: code!=`EQ
  - BLT: code==`LT
  - BGE: code!=`LT
  - BLE: code!=`GT
  - BGT: code==`GT
  - Reserved ops resolve not-taken.
- Resolution outputs (registered; first cycle after CMP, one-cycle pulse):
  - resp_valid=1, resp_taken, mispredict.
  - redirect_pc = taken ? pc+imm : pc+PC_INC, using 32-bit wrap-around addition.
  - redirect_valid=1 only if mispredict.
  - Next state: mispredict ? FLUSH : IDLE.
- No-mispredict path: the controller is back in IDLE with req_ready=1 in the same cycle the resp pulse is visible. Total latency from accept to resp_valid is 2 cycles.
- FLUSH:
  - flush=1 and req_ready=0 for exactly FLUSH_CYCLES cycles, the first of which coincides with the redirect_valid cycle.
  - A 4-bit down-counter is loaded with FLUSH_CYCLES-1; the state returns to IDLE when it reaches 0.
- kill:
  - In CMP: return to IDLE next cycle; no resp_valid, no redirect, no flush.
  - In IDLE: kill has priority over accept, and the request is not taken.
  - In FLUSH: ignored.
- req_valid while not ready is ignored; the requester must hold it.
- Reset asserted mid-operation: immediate return to the reset values. An in-flight branch is dropped with no resp.

Test Plan:
- BEQ a=5 b=5 pred_taken=0 pc=0x100 imm=0x20:
  - cmp_c=0 in CMP.
  - 2 cycles after accept: resp_valid=1, resp_taken=1, mispredict=1, redirect_valid=1, redirect_pc=0x120.
  - flush high 2 cycles; req_ready low 3 cycles total, then 1.
- BLT a=0x8000_0000 b=1 pred_taken=1:
  - Overflow path, cmp_c=0x8000_0001, comparator returns `LT.
  - resp_taken=1, mispredict=0, no redirect, no flush.
  - req_ready=1 on the resp cycle.
- BGE a=3 b=7 pred_taken=1 pc=0xFFFF_FFFC:
  - resp_taken=0, mispredict=1, redirect_pc=0x0000_0000 (wrap-around).
- Back-to-back: BNE 1,2 followed immediately by BGT 9,4, both correctly predicted taken:
  - Second request accepted on the first request's resp cycle.
  - Two resp_valid pulses 2 cycles apart; flush never asserted.
- kill asserted during CMP of a mispredicting BEQ:
  - No resp_valid, no redirect_valid, no flush.
  - IDLE next cycle.
- rst_n dropped during FLUSH with FLUSH_CYCLES=3:
  - flush, busy and the outputs clear immediately, asynchronously.
  - After release, req_ready=1; reserved br_op=7 then resolves not-taken.
